// File: rtl/dsp_pkg.sv
// Shared DSP-chain defaults, the sample type and the frame streamer state encoding.
// No logic here.
// No flow control here.
package dsp_pkg;
  localparam int DEF_SAMPLE_BITS = 12;
  localparam int DEF_WINDOW_SIZE = 128;

  typedef logic [DEF_SAMPLE_BITS-1:0] sample_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;
endpackage

// File: rtl/frame_bank.sv
// One frame buffer: whole-frame parallel write, single indexed read.
// Write lands one cycle after wr_en; read is combinational from stored contents.
// No backpressure; the owner decides when to write.
module frame_bank #(
  parameter int SAMPLE_BITS = 12,
  parameter int WINDOW_SIZE = 128,
  parameter int IDX_W       = $clog2(WINDOW_SIZE)
) (
  input  logic                                    clk,
  input  logic                                    wr_en,
  input  logic [0:WINDOW_SIZE-1][SAMPLE_BITS-1:0] wr_frame,
  input  logic [IDX_W-1:0]                        rd_idx,
  output logic [SAMPLE_BITS-1:0]                  rd_data
);
  logic [0:WINDOW_SIZE-1][SAMPLE_BITS-1:0] mem_q;
  logic [0:WINDOW_SIZE-1][SAMPLE_BITS-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d = wr_frame;
  end

  // Contents are deliberately not reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/frame_streamer.sv
// Serialises parallel windowed frames into a sample stream with one-frame look-ahead buffering.
// Latency: first sample valid one cycle after the capturing frame_valid.
// Backpressure: m_ready stalls the stream; a third frame arriving while both banks are busy is dropped.
module frame_streamer
  import dsp_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [0:WINDOW_SIZE-1][SAMPLE_BITS-1:0] frame_in,
  input  logic                                    frame_valid,
  output logic [SAMPLE_BITS-1:0]                  m_data,
  output logic [$clog2(WINDOW_SIZE)-1:0]          m_index,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic                                    m_last,
  output logic                                    overflow,
  output logic [7:0]                              drop_count
);
  localparam int IDX_W = $clog2(WINDOW_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_SIZE - 1);

  stream_state_e    state_q, state_d;
  logic             act_sel_q, act_sel_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic                   wr_act, wr_pend;
  logic [1:0]             wr_en;
  logic [SAMPLE_BITS-1:0] rd_data [2];
  logic                   xfer, eof;

  assign m_valid = (state_q == STREAM);
  assign xfer    = m_valid && m_ready;
  assign eof     = xfer && (idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    act_sel_d  = act_sel_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    wr_act     = 1'b0;
    wr_pend    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          wr_act  = 1'b1;
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (xfer) idx_d = idx_q + IDX_W'(1);
        if (eof) begin
          idx_d = '0;
          if (pend_q) begin
            // The retiring bank is free again, so a coincident frame refills it as the new pending.
            act_sel_d = !act_sel_q;
            pend_d    = frame_valid;
            wr_act    = frame_valid;
          end else if (frame_valid) begin
            wr_act = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (frame_valid) begin
          if (!pend_q) begin
            wr_pend = 1'b1;
            pend_d  = 1'b1;
          end else begin
            overflow_d = 1'b1;
            drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en = 2'b00;
    if (!rst) begin
      if (wr_act)  wr_en[act_sel_q]  = 1'b1;
      if (wr_pend) wr_en[!act_sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      act_sel_q  <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      act_sel_q  <= act_sel_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .SAMPLE_BITS(SAMPLE_BITS),
      .WINDOW_SIZE(WINDOW_SIZE),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en[b]),
      .wr_frame(frame_in),
      .rd_idx  (idx_q),
      .rd_data (rd_data[b])
    );
  end

  assign m_data     = m_valid ? rd_data[act_sel_q] : '0;
  assign m_index    = idx_q;
  assign m_last     = m_valid && (idx_q == LAST_IDX);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: stimulus pushes expected samples, a negedge monitor checks them.
module tb_frame_streamer;
  import dsp_pkg::*;

  localparam int SB = 12;
  localparam int W  = 128;
  localparam int IW = 7;

  typedef logic [0:W-1][SB-1:0] frame_t;
  typedef struct {
    logic [SB-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  frame_t        frame_in;
  logic          frame_valid;
  logic [SB-1:0] m_data;
  logic [IW-1:0] m_index;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          overflow;
  logic [7:0]    drop_count;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   bubble_cnt = 0;

  frame_streamer #(.SAMPLE_BITS(SB), .WINDOW_SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Monitor: every presented sample must match the head of the queue, stalled or not.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_output: got idx %0d data %0h, required no output", m_index, m_data);
      end else begin
        exp_t e;
        e = sb[0];
        ncmp++;
        if (m_data !== e.d || m_index !== e.i || m_last !== e.l) begin
          nfail++;
          $display("FAIL stream_sample: got data %0h idx %0d last %0b, required data %0h idx %0d last %0b",
                   m_data, m_index, m_last, e.d, e.i, e.l);
        end
        if (m_ready) void'(sb.pop_front());
      end
    end else if (!rst && sb.size() > 0) begin
      bubble_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input frame_t f);
    frame_in    = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic push_frame(input frame_t f);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.d = f[i];
      e.i = IW'(i);
      e.l = (i == W - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    repeat (2) tick();
    check({name, "_idle_after"}, m_valid, 0);
  endtask

  task automatic wait_index(input string name, input int idx);
    int n = 0;
    while (!(m_valid && m_index == IW'(idx)) && n < 600) begin
      tick();
      n++;
    end
    check({name, "_reached"}, (n < 600), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa, fb, fc;
    int b0, k;
    rst = 1'b1;
    frame_valid = 1'b0;
    m_ready = 1'b1;
    frame_in = '0;
    for (int i = 0; i < W; i++) fa[i] = 12'hABC;
    frame_in = fa;
    frame_valid = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    frame_valid = 1'b0;
    rst = 1'b0;

    // Basic stream: ramp data, latency of one cycle.
    for (int i = 0; i < W; i++) fa[i] = SB'(i);
    strobe(fa);
    push_frame(fa);
    check("basic_latency_valid", m_valid, 1);
    check("basic_first_index", m_index, 0);
    drain("basic");

    // Backpressure: ready pattern 1,0,0,1.
    for (int i = 0; i < W; i++) fa[i] = SB'(12'hFFF - i);
    strobe(fa);
    push_frame(fa);
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      m_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
      k++;
    end
    m_ready = 1'b1;
    drain("backpressure");

    // Back-to-back frames with no bubble at the boundary.
    b0 = bubble_cnt;
    for (int i = 0; i < W; i++) begin
      fa[i] = 12'h0AA;
      fb[i] = 12'h155;
    end
    strobe(fa);
    push_frame(fa);
    repeat (9) tick();
    strobe(fb);
    push_frame(fb);
    drain("b2b");
    check("b2b_no_bubble", bubble_cnt - b0, 0);

    // Coincident strobe on the last transfer of A with B pending.
    for (int i = 0; i < W; i++) begin
      fa[i] = 12'h111;
      fb[i] = SB'(i * 3);
      fc[i] = SB'(12'h800 + i);
    end
    strobe(fa);
    push_frame(fa);
    repeat (3) tick();
    strobe(fb);
    push_frame(fb);
    wait_index("coinc_a_last", W - 1);
    strobe(fc);
    push_frame(fc);
    drain("coinc");
    check("coinc_overflow", overflow, 0);
    check("coinc_drop_count", drop_count, 0);

    // Overflow: third frame dropped while stalled.
    m_ready = 1'b0;
    for (int i = 0; i < W; i++) begin
      fa[i] = 12'h001;
      fb[i] = 12'h002;
      fc[i] = 12'h003;
    end
    strobe(fa);
    push_frame(fa);
    tick();
    strobe(fb);
    push_frame(fb);
    tick();
    check("ovf_before_drop", overflow, 0);
    strobe(fc);
    check("ovf_overflow", overflow, 1);
    check("ovf_drop_count", drop_count, 1);
    m_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", overflow, 1);

    // Reset mid-stream at index 50.
    for (int i = 0; i < W; i++) fa[i] = SB'(12'h300 + i);
    strobe(fa);
    push_frame(fa);
    wait_index("rst_mid", 50);
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rstmid_m_valid", m_valid, 0);
    check("rstmid_drop_count", drop_count, 0);
    check("rstmid_overflow", overflow, 0);
    sb.delete();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < W; i++) fb[i] = SB'(12'hC00 + i);
    strobe(fb);
    push_frame(fb);
    check("rstmid_restart_valid", m_valid, 1);
    check("rstmid_restart_index", m_index, 0);
    drain("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
